// File: rtl/mmio_memory_bus.sv
// mmio_memory_bus
// Memory-side slave for the multicycle RV32I core. Every core access is
// decoded to one of three targets: a word-addressed RAM (mem_addr[31]=0),
// a small MMIO register bank (LEDS, CYCLE) or a buffered 8N1 UART
// transmitter (UART_DATA, UART_STATUS). Read data is combinational.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   mem_addr     byte address from the core (bits [1:0] ignored)
//   mem_wr_data  write data
//   mem_wr_ena   write strobe, commits on the rising edge
//   mem_rd_data  combinational read data for mem_addr
//   leds         LED register contents
//   uart_tx      serial output, idle high
module mmio_memory_bus #(
    parameter int RAM_WORDS    = 256,
    parameter int LED_W        = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wr_data,
    input  logic             mem_wr_ena,
    output logic [31:0]      mem_rd_data,
    output logic [LED_W-1:0] leds,
    output logic             uart_tx
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [PW-1:0] PTR_LAST   = PW'(FIFO_DEPTH - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    COUNT_FULL = 4'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    logic [31:0]     ram [RAM_WORDS];
    logic [31:0]     cycle;
    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [3:0]      count;
    logic            overflow;
    tx_state_t       state;
    tx_state_t       state_next;
    logic [TW-1:0]   timer;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;

    logic            is_mmio;
    logic [5:0]      reg_sel;
    logic [AW-1:0]   ram_idx;
    logic            ram_we;
    logic            led_we;
    logic            cycle_we;
    logic            push_req;
    logic            status_we;
    logic            full;
    logic            busy;
    logic            pop;
    logic            push_ok;
    logic            overflow_set;
    logic            bit_done;
    logic            unused_addr;

    // Address decode: bit 31 splits RAM from MMIO; the MMIO bank is decoded
    // on word offset mem_addr[7:2], everything above is don't-care.
    assign is_mmio   = mem_addr[31];
    assign reg_sel   = mem_addr[7:2];
    assign ram_idx   = mem_addr[2 +: AW];
    assign ram_we    = mem_wr_ena && !is_mmio;
    assign led_we    = mem_wr_ena && is_mmio && (reg_sel == 6'd0);
    assign cycle_we  = mem_wr_ena && is_mmio && (reg_sel == 6'd1);
    assign push_req  = mem_wr_ena && is_mmio && (reg_sel == 6'd2);
    assign status_we = mem_wr_ena && is_mmio && (reg_sel == 6'd3);
    assign unused_addr = ^{mem_addr[30:8], mem_addr[1:0]};

    assign full     = (count == COUNT_FULL);
    assign busy     = (state != IDLE) || (count != 4'd0);
    assign bit_done = (timer == TIMER_LAST);

    // A push into a full FIFO still fits when the transmitter pops the
    // oldest byte on the same edge; otherwise it is dropped and flagged.
    assign push_ok      = push_req && (!full || pop);
    assign overflow_set = push_req && full && !pop;

    // Combinational read mux.
    always_comb begin
        mem_rd_data = 32'd0;
        if (!is_mmio) begin
            mem_rd_data = ram[ram_idx];
        end else begin
            case (reg_sel)
                6'd0:    mem_rd_data = 32'(leds);
                6'd1:    mem_rd_data = cycle;
                6'd3:    mem_rd_data = {24'd0, count, 1'b0, overflow, busy, full};
                default: mem_rd_data = 32'd0;
            endcase
        end
    end

    // RAM contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_idx] <= mem_wr_data;
        end
    end

    // LED register and free-running cycle counter; a CYCLE write replaces
    // that cycle's increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            leds  <= '0;
            cycle <= 32'd0;
        end else begin
            if (led_we) begin
                leds <= mem_wr_data[LED_W-1:0];
            end
            if (cycle_we) begin
                cycle <= mem_wr_data;
            end else begin
                cycle <= cycle + 32'd1;
            end
        end
    end

    // FIFO byte storage needs no reset; only pointers and count matter.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= mem_wr_data[7:0];
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag. Setting the
    // flag takes priority over a write-one-to-clear on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= 4'd0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
            if (overflow_set) begin
                overflow <= 1'b1;
            end else if (status_we && mem_wr_data[2]) begin
                overflow <= 1'b0;
            end
        end
    end

    // Transmitter state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Transmitter next-state, pop request and line level.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        uart_tx    = 1'b1;
        case (state)
            IDLE: begin
                if (count != 4'd0) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                uart_tx = 1'b0;
                if (bit_done) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                uart_tx = shift[0];
                if (bit_done && (bit_idx == 3'd7)) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Bit timer, bit index and shift register. The timer restarts on every
    // pop and at the end of each bit period; data leaves LSB first.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer   <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'd0;
        end else if (pop) begin
            shift   <= fifo_mem[rd_ptr];
            timer   <= '0;
            bit_idx <= 3'd0;
        end else if (state != IDLE) begin
            timer <= bit_done ? '0 : timer + 1'b1;
            if (state == DATA && bit_done) begin
                shift   <= shift >> 1;
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

endmodule
